// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register index, controller FSM state, and the one-hot hazard vector.
// Types only; no logic, no latency, no backpressure.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HALT_DRAIN = 2'd1,
        HALTED     = 2'd2
    } pipe_state_t;

    // At most one field is set: the highest-priority hazard active this cycle.
    typedef struct packed {
        logic dmem;
        logic mispred;
        logic load_use;
        logic jump;
        logic imem;
    } hazard_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> hazard controller bundle: pipeline status in, latch enables/flushes out.
// Pure wiring; master is the controller, slave is the datapath side.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic                     ihit;
    logic                     dhit;
    cpu_types_pkg::regbits_t  id_rs;
    cpu_types_pkg::regbits_t  id_rt;
    logic                     id_jump;
    logic                     id_halt;
    logic                     ex_dREN;
    cpu_types_pkg::regbits_t  ex_regDst;
    logic                     ex_branch;
    logic                     ex_br_pred;
    logic                     ex_br_actual;
    logic                     mem_dREN;
    logic                     mem_dWEN;

    logic                     pc_en;
    logic                     fd_en;
    logic                     fd_flush;
    logic                     de_en;
    logic                     de_flush;
    logic                     em_en;
    logic                     em_flush;
    logic                     mw_en;
    logic                     halted;
    logic [CNT_W-1:0]         bubble_cnt;

    modport master (
        input  ihit, dhit, id_rs, id_rt, id_jump, id_halt,
               ex_dREN, ex_regDst, ex_branch, ex_br_pred, ex_br_actual,
               mem_dREN, mem_dWEN,
        output pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush,
               mw_en, halted, bubble_cnt
    );

    modport slave (
        output ihit, dhit, id_rs, id_rt, id_jump, id_halt,
               ex_dREN, ex_regDst, ex_branch, ex_br_pred, ex_br_actual,
               mem_dREN, mem_dWEN,
        input  pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush,
               mw_en, halted, bubble_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Priority encoder of pipeline hazards into a one-hot vector (dmem > mispred > load-use > jump > imem).
// Purely combinational, zero latency; no handshake.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     i_ihit,
    input  logic     i_dhit,
    input  regbits_t i_id_rs,
    input  regbits_t i_id_rt,
    input  logic     i_id_jump,
    input  logic     i_ex_dREN,
    input  regbits_t i_ex_regDst,
    input  logic     i_ex_branch,
    input  logic     i_ex_br_pred,
    input  logic     i_ex_br_actual,
    input  logic     i_mem_dREN,
    input  logic     i_mem_dWEN,
    output hazard_t  o_hz
);
    logic w_dmem, w_mispred, w_load_use, w_jump, w_imem;

    assign w_dmem     = (i_mem_dREN | i_mem_dWEN) & ~i_dhit;
    assign w_mispred  = i_ex_branch & (i_ex_br_pred != i_ex_br_actual);
    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign w_load_use = i_ex_dREN & (i_ex_regDst != '0) &
                        ((i_ex_regDst == i_id_rs) | (i_ex_regDst == i_id_rt));
    assign w_jump     = i_id_jump;
    assign w_imem     = ~i_ihit;

    always_comb begin
        o_hz          = '0;
        o_hz.dmem     = w_dmem;
        o_hz.mispred  = w_mispred  & ~w_dmem;
        o_hz.load_use = w_load_use & ~w_dmem & ~w_mispred;
        o_hz.jump     = w_jump     & ~w_dmem & ~w_mispred & ~w_load_use;
        o_hz.imem     = w_imem     & ~w_dmem & ~w_mispred & ~w_load_use & ~w_jump;
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard/halt controller driving PC and latch enables/flushes plus a bubble counter.
// Outputs are combinational (zero latency); a pending data access freezes every stage.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic           CLK,
    input  logic           RST,
    pipeline_ctrl_if.master bus
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    pipe_state_t      r_state;
    logic [DW-1:0]    r_drain_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    hazard_t w_hz;
    logic    w_pc_en, w_fd_en, w_fd_flush, w_de_en, w_de_flush;
    logic    w_em_en, w_em_flush, w_mw_en, w_halted;
    logic    w_halt_accept, w_bubble;

    hazard_detect u_hazard_detect (
        .i_ihit         (bus.ihit),
        .i_dhit         (bus.dhit),
        .i_id_rs        (bus.id_rs),
        .i_id_rt        (bus.id_rt),
        .i_id_jump      (bus.id_jump),
        .i_ex_dREN      (bus.ex_dREN),
        .i_ex_regDst    (bus.ex_regDst),
        .i_ex_branch    (bus.ex_branch),
        .i_ex_br_pred   (bus.ex_br_pred),
        .i_ex_br_actual (bus.ex_br_actual),
        .i_mem_dREN     (bus.mem_dREN),
        .i_mem_dWEN     (bus.mem_dWEN),
        .o_hz           (w_hz)
    );

    // A mispredict squashes the HALT in ID; stalls just defer it.
    assign w_halt_accept = (r_state == RUN) & bus.id_halt &
                           ~(w_hz.dmem | w_hz.mispred | w_hz.load_use);
    assign w_bubble = w_hz.mispred | w_hz.load_use | w_hz.jump | w_hz.imem |
                      ((r_state == HALT_DRAIN) & ~w_hz.dmem);

    always_comb begin
        w_pc_en    = 1'b0;
        w_fd_en    = 1'b0;
        w_fd_flush = 1'b0;
        w_de_en    = 1'b0;
        w_de_flush = 1'b0;
        w_em_en    = 1'b0;
        w_em_flush = 1'b0;
        w_mw_en    = 1'b0;
        w_halted   = 1'b0;
        if (!RST) begin
            case (r_state)
                RUN, HALT_DRAIN: begin
                    if (!w_hz.dmem) begin
                        w_pc_en = 1'b1;
                        w_fd_en = 1'b1;
                        w_de_en = 1'b1;
                        w_em_en = 1'b1;
                        w_mw_en = 1'b1;
                        if (r_state == HALT_DRAIN || w_halt_accept) begin
                            w_pc_en    = 1'b0;
                            w_fd_flush = 1'b1;
                        end
                        if (r_state == RUN) begin
                            if (w_hz.mispred) begin
                                w_fd_flush = 1'b1;
                                w_de_flush = 1'b1;
                            end else if (w_hz.load_use) begin
                                w_pc_en    = 1'b0;
                                w_fd_en    = 1'b0;
                                w_de_flush = 1'b1;
                            end else if (w_hz.jump) begin
                                w_fd_flush = 1'b1;
                            end else if (w_hz.imem) begin
                                w_pc_en    = 1'b0;
                                w_fd_flush = 1'b1;
                            end
                        end
                    end
                end
                HALTED:  w_halted = 1'b1;
                default: w_halted = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= RUN;
            r_drain_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_bubble && r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            case (r_state)
                RUN: begin
                    if (w_halt_accept) begin
                        r_state     <= HALT_DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                HALT_DRAIN: begin
                    if (!w_hz.dmem) begin
                        if (r_drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                            r_state     <= HALTED;
                            r_drain_cnt <= '0;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + DW'(1);
                        end
                    end
                end
                HALTED:  r_state <= HALTED;
                default: r_state <= RUN;
            endcase
        end
    end

    assign bus.pc_en      = w_pc_en;
    assign bus.fd_en      = w_fd_en;
    assign bus.fd_flush   = w_fd_flush;
    assign bus.de_en      = w_de_en;
    assign bus.de_flush   = w_de_flush;
    assign bus.em_en      = w_em_en;
    assign bus.em_flush   = w_em_flush;
    assign bus.mw_en      = w_mw_en;
    assign bus.halted     = w_halted;
    assign bus.bubble_cnt = r_bubble_cnt;
endmodule
